// File: rtl/pwm_dead_time_ctrl_if.sv
// Bus between the PWM generator / gate-driver side and the dead-time sequencer.
interface pwm_dead_time_ctrl_if #(
   parameter int NUM_LEGS = 3,
   parameter int DT_W     = 16
);
   logic                en;
   logic [NUM_LEGS-1:0] pwm_in;
   logic [DT_W-1:0]     dead_time;
   logic                dt_load;
   logic                fault;
   logic                fault_clr;
   logic [NUM_LEGS-1:0] gate_h;
   logic [NUM_LEGS-1:0] gate_l;
   logic [NUM_LEGS-1:0] dt_busy;
   logic [DT_W-1:0]     dt_active;
   logic                fault_active;

   modport master (
      output en, pwm_in, dead_time, dt_load, fault, fault_clr,
      input  gate_h, gate_l, dt_busy, dt_active, fault_active
   );
   modport slave (
      input  en, pwm_in, dead_time, dt_load, fault, fault_clr,
      output gate_h, gate_l, dt_busy, dt_active, fault_active
   );
endinterface

// File: rtl/pwm_dead_time_ctrl.sv
// N-leg dead-time gate sequencer with shared dead-time register and fault shutdown.
// Define DT_FAULT_LATCH_EN to make faults sticky until fault_clr.
module pwm_dt_leg #(
   parameter int DT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            block,
   input  logic            pwm,
   input  logic [DT_W-1:0] d_eff,
   output logic            gate_h,
   output logic            gate_l,
   output logic            busy
);
   typedef enum logic [2:0] {S_OFF, S_HI, S_DT_HL, S_LO, S_DT_LH} state_e;

   state_e          state_q, state_d;
   logic [DT_W-1:0] cnt_q, cnt_d;
   logic [DT_W-1:0] dcap_q, dcap_d;
   logic            gate_h_q, gate_l_q, busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_OFF;
         cnt_q    <= '0;
         dcap_q   <= DT_W'(1);
         gate_h_q <= 1'b0;
         gate_l_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dcap_q   <= dcap_d;
         gate_h_q <= (state_d == S_HI);
         gate_l_q <= (state_d == S_LO);
         busy_q   <= (state_d == S_DT_HL) || (state_d == S_DT_LH);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dcap_d  = dcap_q;
      if (block || !en) begin
         state_d = S_OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               // First turn-on out of OFF still gets a full guard interval.
               state_d = pwm ? S_DT_LH : S_DT_HL;
               cnt_d   = DT_W'(1);
               dcap_d  = d_eff;
            end
            S_HI: if (!pwm) begin
               state_d = S_DT_HL;
               cnt_d   = DT_W'(1);
               dcap_d  = d_eff;
            end
            S_LO: if (pwm) begin
               state_d = S_DT_LH;
               cnt_d   = DT_W'(1);
               dcap_d  = d_eff;
            end
            S_DT_HL: begin
               // Abort is safe: the low side never turned on.
               if (pwm) begin
                  state_d = S_HI;
                  cnt_d   = '0;
               end else if (cnt_q == dcap_q) begin
                  state_d = S_LO;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + DT_W'(1);
               end
            end
            S_DT_LH: begin
               if (!pwm) begin
                  state_d = S_LO;
                  cnt_d   = '0;
               end else if (cnt_q == dcap_q) begin
                  state_d = S_HI;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + DT_W'(1);
               end
            end
            default: begin
               state_d = S_OFF;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign gate_h = gate_h_q;
   assign gate_l = gate_l_q;
   assign busy   = busy_q;
endmodule

module pwm_dead_time_ctrl #(
   parameter int NUM_LEGS = 3,
   parameter int DT_W     = 16
) (
   input logic                clk,
   input logic                rst,
   pwm_dead_time_ctrl_if.slave bus
);
   logic [DT_W-1:0]     dt_active_q, dt_active_d;
   logic [DT_W-1:0]     shadow_q, shadow_d;
   logic                pend_q, pend_d;
   logic                fault_q, fault_d;
   logic                block;
   logic [DT_W-1:0]     d_eff;
   logic [NUM_LEGS-1:0] gate_h, gate_l, busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dt_active_q <= DT_W'(1);
         shadow_q    <= '0;
         pend_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         dt_active_q <= dt_active_d;
         shadow_q    <= shadow_d;
         pend_q      <= pend_d;
         fault_q     <= fault_d;
      end
   end

   // Pending load moves to the active register only while every leg is idle.
   always_comb begin
      shadow_d    = shadow_q;
      pend_d      = pend_q;
      dt_active_d = dt_active_q;
      if (bus.dt_load) begin
         shadow_d = bus.dead_time;
         pend_d   = 1'b1;
      end
      if (pend_d && (busy == '0)) begin
         dt_active_d = shadow_d;
         pend_d      = 1'b0;
      end
   end

`ifdef DT_FAULT_LATCH_EN
   // Legs use the next latch value so they leave OFF on the clearing edge.
   always_comb begin
      fault_d = bus.fault | (fault_q & ~bus.fault_clr);
      block   = fault_d;
   end
`else
   logic unused_fault_clr;
   assign unused_fault_clr = bus.fault_clr;
   always_comb begin
      fault_d = bus.fault;
      block   = bus.fault;
   end
`endif

   assign d_eff = (dt_active_q == '0) ? DT_W'(1) : dt_active_q;

   for (genvar i = 0; i < NUM_LEGS; i++) begin : g_leg
      pwm_dt_leg #(.DT_W(DT_W)) u_leg (
         .clk    (clk),
         .rst    (rst),
         .en     (bus.en),
         .block  (block),
         .pwm    (bus.pwm_in[i]),
         .d_eff  (d_eff),
         .gate_h (gate_h[i]),
         .gate_l (gate_l[i]),
         .busy   (busy[i])
      );
   end

   assign bus.gate_h       = gate_h;
   assign bus.gate_l       = gate_l;
   assign bus.dt_busy      = busy;
   assign bus.dt_active    = dt_active_q;
   assign bus.fault_active = fault_q;
endmodule
